// File: rtl/snitch_icache_refill.sv
// snitch_icache_refill: splits icache line refills into memory beats and reassembles the lines
module snitch_icache_refill #(
    parameter int unsigned FETCH_AW   = 48,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned MEM_DW     = 64,
    parameter int unsigned PENDING_IW = 2,
    parameter int unsigned MAX_LINES  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [FETCH_AW-1:0]   in_req_addr_i,
    input  logic [PENDING_IW-1:0] in_req_id_i,
    input  logic                  in_req_valid_i,
    output logic                  in_req_ready_o,
    output logic [LINE_WIDTH-1:0] in_rsp_data_o,
    output logic                  in_rsp_error_o,
    output logic [PENDING_IW-1:0] in_rsp_id_o,
    output logic                  in_rsp_valid_o,
    input  logic                  in_rsp_ready_i,
    output logic [FETCH_AW-1:0]   mem_req_addr_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic [MEM_DW-1:0]     mem_rsp_data_i,
    input  logic                  mem_rsp_error_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o
);
    localparam int unsigned BEATS = LINE_WIDTH / MEM_DW;
    localparam int unsigned BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int unsigned BO    = $clog2(MEM_DW / 8);
    localparam int unsigned PW    = MAX_LINES > 1 ? $clog2(MAX_LINES) : 1;
    localparam int unsigned CW    = $clog2(MAX_LINES + 1);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_LINES - 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                state_q, state_d;
    logic [FETCH_AW-1:0]   base_q;
    logic [BW-1:0]         issue_cnt_q, collect_cnt_q;
    logic [PENDING_IW-1:0] tags_q [MAX_LINES];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  line_full_q, err_q;
    logic                  full, req_hs, mem_hs, beat_hs, rsp_hs;

    assign full            = count_q == CW'(MAX_LINES);
    assign req_hs          = in_req_valid_i && in_req_ready_o;
    assign mem_hs          = mem_req_valid_o && mem_req_ready_i;
    assign beat_hs         = mem_rsp_valid_i && mem_rsp_ready_o;
    assign rsp_hs          = in_rsp_valid_o && in_rsp_ready_i;
    assign mem_req_addr_o  = base_q + (FETCH_AW'(issue_cnt_q) << BO);
    assign mem_rsp_ready_o = !line_full_q;
    assign in_rsp_valid_o  = line_full_q;
    assign in_rsp_data_o   = line_q;
    assign in_rsp_error_o  = err_q;
    assign in_rsp_id_o     = tags_q[rptr_q];

    always_comb begin
        state_d         = state_q;
        in_req_ready_o  = 1'b0;
        mem_req_valid_o = 1'b0;
        if (state_q == IDLE) begin
            in_req_ready_o = !full;
            state_d        = (in_req_valid_i && !full) ? ISSUE : IDLE;
        end else begin
            mem_req_valid_o = 1'b1;
            state_d         = (mem_req_ready_i && issue_cnt_q == LAST) ? IDLE : ISSUE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            base_q        <= '0;
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            line_q        <= '0;
            line_full_q   <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 0; i < MAX_LINES; i++) tags_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CW'(req_hs) - CW'(rsp_hs);
            if (req_hs) begin
                base_q         <= in_req_addr_i & ~FETCH_AW'(LINE_WIDTH / 8 - 1);
                tags_q[wptr_q] <= in_req_id_i;
                wptr_q         <= wptr_q == PTR_LAST ? '0 : wptr_q + PW'(1);
            end
            if (mem_hs) issue_cnt_q <= issue_cnt_q == LAST ? '0 : issue_cnt_q + BW'(1);
            // beats and line return never coincide: beats are refused while the line is full
            if (beat_hs) begin
                line_q[collect_cnt_q*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
                err_q         <= err_q | mem_rsp_error_i;
                collect_cnt_q <= collect_cnt_q == LAST ? '0 : collect_cnt_q + BW'(1);
                line_full_q   <= collect_cnt_q == LAST;
            end
            if (rsp_hs) begin
                rptr_q      <= rptr_q == PTR_LAST ? '0 : rptr_q + PW'(1);
                line_full_q <= 1'b0;
                err_q       <= 1'b0;
            end
        end
    end

    a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rsp_valid_i |-> count_q != '0);
endmodule

// File: tb/tb_snitch_icache_refill.sv
// tb_snitch_icache_refill: randomized scoreboard bench with an address-keyed memory model,
// plus a single-beat configuration instance.
module tb_snitch_icache_refill;
    localparam int AW = 32, LW = 128, DW = 32, IW = 2, ML = 2, BEATS = LW / DW;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [AW-1:0] req_addr = '0, mem_req_addr;
    logic [IW-1:0] req_id = '0, rsp_id;
    logic          req_valid = 0, req_ready;
    logic [LW-1:0] rsp_data;
    logic          rsp_error, rsp_valid, rsp_ready = 0;
    logic          mem_req_valid, mem_req_ready = 1;
    logic [DW-1:0] mem_rsp_data = '0;
    logic          mem_rsp_error = 0, mem_rsp_valid = 0, mem_rsp_ready;

    snitch_icache_refill #(.FETCH_AW(AW), .LINE_WIDTH(LW), .MEM_DW(DW), .PENDING_IW(IW), .MAX_LINES(ML)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_req_addr_i(req_addr), .in_req_id_i(req_id), .in_req_valid_i(req_valid), .in_req_ready_o(req_ready),
        .in_rsp_data_o(rsp_data), .in_rsp_error_o(rsp_error), .in_rsp_id_o(rsp_id),
        .in_rsp_valid_o(rsp_valid), .in_rsp_ready_i(rsp_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_rsp_data_i(mem_rsp_data), .mem_rsp_error_i(mem_rsp_error), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_ready_o(mem_rsp_ready));

    // Single-beat instance (MEM_DW == LINE_WIDTH)
    logic [AW-1:0] b_req_addr = '0, b_mem_req_addr;
    logic [IW-1:0] b_req_id = '0, b_rsp_id;
    logic          b_req_valid = 0, b_req_ready, b_rsp_error, b_rsp_valid;
    logic [LW-1:0] b_rsp_data, b_mem_rsp_data = '0;
    logic          b_mem_req_valid, b_mem_rsp_valid = 0, b_mem_rsp_ready;

    snitch_icache_refill #(.FETCH_AW(AW), .LINE_WIDTH(LW), .MEM_DW(LW), .PENDING_IW(IW), .MAX_LINES(ML)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_req_addr_i(b_req_addr), .in_req_id_i(b_req_id), .in_req_valid_i(b_req_valid), .in_req_ready_o(b_req_ready),
        .in_rsp_data_o(b_rsp_data), .in_rsp_error_o(b_rsp_error), .in_rsp_id_o(b_rsp_id),
        .in_rsp_valid_o(b_rsp_valid), .in_rsp_ready_i(1'b1),
        .mem_req_addr_o(b_mem_req_addr), .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(1'b1),
        .mem_rsp_data_i(b_mem_rsp_data), .mem_rsp_error_i(1'b0), .mem_rsp_valid_i(b_mem_rsp_valid),
        .mem_rsp_ready_o(b_mem_rsp_ready));

    typedef struct {logic [LW-1:0] data; logic [IW-1:0] id; logic err;} line_t;
    line_t         sb[$];
    logic [AW-1:0] exp_addr[$], pend[$];
    int            errors = 0, checks = 0;
    int            mrdy_mode = 0, rrdy_mode = 1;
    logic          rsp_taken = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory contents as a pure function of the beat address
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a[31:8] == 24'h100000) ? 32'h11 * (32'(a[3:2]) + 1) : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction
    function automatic logic mem_err(input logic [AW-1:0] a);
        return a[15:12] == 4'hE && a[3:2] == 2'd2;
    endfunction

    task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id);
        int n = 0;
        line_t l;
        logic [AW-1:0] base = a & ~32'hF;
        @(posedge clk); #1;
        req_valid = 1; req_addr = a; req_id = id;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            if (++n > 500) begin chk("req_accept_timeout", 0, 1); break; end
        end
        if (n <= 500) begin
            l.id = id; l.err = 0; l.data = '0;
            for (int k = 0; k < BEATS; k++) begin
                l.data[k*DW +: DW] = mem_data(base + 32'(4 * k));
                l.err |= mem_err(base + 32'(4 * k));
                exp_addr.push_back(base + 32'(4 * k));
            end
            sb.push_back(l);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || exp_addr.size() != 0 || pend.size() != 0) && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) chk("drain_timeout", 0, 1);
    endtask

    // Memory side: request readiness and in-order beat responses
    always begin
        logic hold;
        @(posedge clk); #1;
        mem_req_ready = mrdy_mode == 0 ? 1'b1 : mrdy_mode == 1 ? ~mem_req_ready : 1'($urandom);
        rsp_ready     = rrdy_mode == 0 ? 1'b0 : rrdy_mode == 1 ? 1'b1 : 1'($urandom);
        hold = mem_rsp_valid && !rsp_taken;
        rsp_taken = 0;
        mem_rsp_valid = pend.size() != 0 && (hold || $urandom_range(0, 3) != 0);
        mem_rsp_data  = pend.size() != 0 ? mem_data(pend[0]) : '0;
        mem_rsp_error = pend.size() != 0 ? mem_err(pend[0]) : 1'b0;
    end

    // Memory request monitor
    always begin
        logic          mhold = 0;
        logic [AW-1:0] maddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete(); exp_addr.delete(); mhold = 0;
            end else begin
                if (mhold) chk("mem_req_stable", {mem_req_valid, mem_req_addr}, {1'b1, maddr});
                mhold = mem_req_valid && !mem_req_ready;
                maddr = mem_req_addr;
                if (mem_rsp_valid && mem_rsp_ready) begin
                    void'(pend.pop_front()); rsp_taken = 1;
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_addr.size() == 0) chk("mem_req_unexpected", mem_req_addr, 0);
                    else chk("mem_req_addr", mem_req_addr, exp_addr.pop_front());
                    pend.push_back(mem_req_addr);
                end
            end
        end
    end

    // Response monitor against the scoreboard
    always begin
        logic         rhold = 0;
        logic [131:0] rsnap = '0;
        line_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete(); rhold = 0;
            end else begin
                if (rhold) chk("rsp_stable", {rsp_valid, rsp_data, rsp_id, rsp_error}, rsnap);
                rhold = rsp_valid && !rsp_ready;
                rsnap = {rsp_valid, rsp_data, rsp_id, rsp_error};
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) chk("rsp_unexpected", rsp_id, 0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_error", rsp_error, e.err);
                    end
                end
            end
        end
    end

    initial begin
        logic [LW-1:0] d;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {req_ready, mem_req_valid, mem_rsp_ready, rsp_valid, rsp_data, rsp_id, rsp_error},
            {1'b1, 1'b0, 1'b1, 1'b0, 128'h0, 2'h0, 1'b0});
        @(posedge clk); #1 rst = 0;

        // Directed line, error line, then clean line
        send(32'h1000_0017, 2);
        drain();
        send(32'h0000_E000, 1);
        send(32'h0000_D000, 3);
        drain();

        // FIFO full stall with response port blocked
        rrdy_mode = 0;
        send(32'h100, 0);
        send(32'h200, 1);
        fork
            send(32'h300, 3);
            begin
                repeat (20) @(negedge clk);
                chk("fifo_full_stall", {req_ready, rsp_valid}, {1'b0, 1'b1});
                rrdy_mode = 1;
            end
        join
        drain();

        // Toggling memory readiness, random response readiness
        mrdy_mode = 1; rrdy_mode = 2;
        for (int i = 0; i < 12; i++) send($urandom, 2'($urandom_range(0, 3)));
        drain();

        // Reset while issuing beat 2
        mrdy_mode = 0; rrdy_mode = 1;
        fork send(32'h4000, 2); join_none
        for (int n = 0; n < 200 && exp_addr.size() != 2; n++) @(negedge clk);
        chk("reset_reach_beat2", 32'(exp_addr.size()), 2);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midreset_outputs", {req_ready, mem_req_valid, rsp_valid, rsp_data},
            {1'b1, 1'b0, 1'b0, 128'h0});
        send(32'h5000, 1);
        drain();

        // Fully random traffic
        mrdy_mode = 2; rrdy_mode = 2;
        for (int i = 0; i < 20; i++) send($urandom, 2'($urandom_range(0, 3)));
        drain();

        // Single-beat configuration
        d = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        b_req_valid = 1; b_req_addr = 32'h2000_0035; b_req_id = 0;
        @(negedge clk);
        chk("b_req_ready", b_req_ready, 1);
        @(posedge clk); #1 b_req_valid = 0;
        @(negedge clk);
        chk("b_mem_req", {b_mem_req_valid, b_mem_req_addr}, {1'b1, 32'h2000_0030});
        @(posedge clk); #1;
        b_mem_rsp_valid = 1; b_mem_rsp_data = d;
        @(negedge clk);
        chk("b_collect", {b_mem_rsp_ready, b_rsp_valid, b_mem_req_valid}, {1'b1, 1'b0, 1'b0});
        @(posedge clk); #1 b_mem_rsp_valid = 0;
        @(negedge clk);
        chk("b_rsp", {b_rsp_valid, b_rsp_data, b_rsp_id, b_rsp_error}, {1'b1, d, 2'h0, 1'b0});
        @(negedge clk);
        chk("b_rsp_done", b_rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
